// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared encodings and limits for the memory port arbiter
package arbiter_pkg;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] WAIT   = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
  localparam int MAX_RD_LATENCY = 3;
  localparam int CNT_W = $clog2(MAX_RD_LATENCY);
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, response and memory signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic req0, req1, we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic gnt0, gnt1, ack0, ack1, cpu_stall;
  logic [WIDTH-1:0] rdata;
  logic mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, cpu_stall, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, cpu_stall, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_select2.sv
// rr_select2: two-way round-robin pick, the port that did not go last wins a tie
module rr_select2
  import arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);
  // tie goes to the port that did not own the previous transaction
  always_comb begin
    valid  = req0 || req1;
    winner = (req0 && req1) ? (last_owner == PORT_CPU ? PORT_LDR : PORT_CPU)
                            : (req0 ? PORT_CPU : PORT_LDR);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and loader accesses onto one fixed-latency memory
module mem_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, we_q, we_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic valid, winner, grant, done_entry;

  rr_select2 u_rr (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_owner(last_q),
    .valid     (valid),
    .winner    (winner)
  );

  // grants come only from IDLE and are suppressed while reset is held
  assign grant      = rst && state_q == IDLE && valid;
  assign done_entry = (state_q == ACCESS && (we_q || RD_LATENCY == 1)) ||
                      (state_q == WAIT && cnt_q <= CNT_W'(1));

  // next state, transaction latch, latency countdown and completion capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ack0_d  = done_entry && owner_q == PORT_CPU;
    ack1_d  = done_entry && owner_q == PORT_LDR;
    rdata_d = (done_entry && !we_q) ? bus.mem_rdata : rdata_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = ACCESS;
        owner_d = winner;
        last_d  = winner;
        we_d    = winner == PORT_LDR ? bus.we1 : bus.we0;
        addr_d  = winner == PORT_LDR ? bus.addr1 : bus.addr0;
        wdata_d = winner == PORT_LDR ? bus.wdata1 : bus.wdata0;
      end
      ACCESS: begin
        state_d = done_entry ? DONE : WAIT;
        cnt_d   = CNT_W'(RD_LATENCY - 1);
      end
      WAIT: begin
        state_d = done_entry ? DONE : WAIT;
        cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= PORT_LDR;
      owner_q <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.gnt0      = grant && winner == PORT_CPU;
  assign bus.gnt1      = grant && winner == PORT_LDR;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.cpu_stall = bus.req0 && !ack0_q;
  assign bus.mem_en    = state_q == ACCESS;
  assign bus.mem_we    = state_q == ACCESS && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic on three arbiters (read latency 1..3) against a transaction-level model
module tb_mem_port_arbiter;
  localparam int W = 32;
  localparam int AW = 32;
  localparam int N = 3;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a[N], req0_a[N], req1_a[N], we0_a[N], we1_a[N];
  logic [AW-1:0] addr0_a[N], addr1_a[N];
  logic [W-1:0] wdata0_a[N], wdata1_a[N], mrd_a[N];
  logic gnt0_a[N], gnt1_a[N], ack0_a[N], ack1_a[N], stall_a[N], en_a[N], mwe_a[N];
  logic [AW-1:0] maddr_a[N];
  logic [W-1:0] mwdata_a[N], rdata_a[N];

  for (genvar g = 0; g < N; g++) begin : inst
    mem_port_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .RD_LATENCY(g + 1)) dut (
      .clk(clk),
      .rst(rst_a[g]),
      .bus(bus)
    );
    assign bus.req0      = req0_a[g];
    assign bus.req1      = req1_a[g];
    assign bus.we0       = we0_a[g];
    assign bus.we1       = we1_a[g];
    assign bus.addr0     = addr0_a[g];
    assign bus.addr1     = addr1_a[g];
    assign bus.wdata0    = wdata0_a[g];
    assign bus.wdata1    = wdata1_a[g];
    assign bus.mem_rdata = mrd_a[g];
    assign gnt0_a[g]     = bus.gnt0;
    assign gnt1_a[g]     = bus.gnt1;
    assign ack0_a[g]     = bus.ack0;
    assign ack1_a[g]     = bus.ack1;
    assign stall_a[g]    = bus.cpu_stall;
    assign en_a[g]       = bus.mem_en;
    assign mwe_a[g]      = bus.mem_we;
    assign maddr_a[g]    = bus.mem_addr;
    assign mwdata_a[g]   = bus.mem_wdata;
    assign rdata_a[g]    = bus.rdata;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: a transaction is granted at cycle T and completes at T+dur
  bit m_busy[N];
  int m_t[N], m_dur[N];
  logic m_owner[N], m_we[N], m_last[N], eg0[N];
  logic [AW-1:0] m_addr[N];
  logic [W-1:0] m_wdata[N], m_rdata[N];

  task automatic model_reset(input int k);
    m_busy[k] = 0;
    m_t[k] = 0;
    m_dur[k] = 0;
    m_owner[k] = 0;
    m_we[k] = 0;
    m_last[k] = 1;
    m_addr[k] = '0;
    m_wdata[k] = '0;
    m_rdata[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_a[k] = 0; req0_a[k] = 0; req1_a[k] = 0; we0_a[k] = 0; we1_a[k] = 0;
      addr0_a[k] = '0; addr1_a[k] = '0; wdata0_a[k] = '0; wdata1_a[k] = '0; mrd_a[k] = '0;
      eg0[k] = 0;
      model_reset(k);
    end
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      int dens;
      dens = ((cyc / 400) % 3 == 0) ? 100 : (((cyc / 400) % 3 == 1) ? 35 : 70);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        rst_a[k] = (cyc < 2) ? 1'b0 : ($urandom_range(0, 79) != 0);
        if (!(req0_a[k] && !eg0[k] && $urandom_range(0, 15) != 0)) begin
          req0_a[k]   = $urandom_range(0, 99) < dens;
          we0_a[k]    = 1'($urandom_range(0, 1));
          addr0_a[k]  = $urandom;
          wdata0_a[k] = $urandom;
        end
        if (!(req1_a[k] && !gnt1_a[k] && $urandom_range(0, 15) != 0)) begin
          req1_a[k]   = $urandom_range(0, 99) < dens;
          we1_a[k]    = 1'($urandom_range(0, 1));
          addr1_a[k]  = $urandom;
          wdata1_a[k] = $urandom;
        end
        mrd_a[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        logic w, v, e_g0, e_g1, e_a0, e_a1, e_en, e_we;
        string p;
        p = $sformatf("L%0d", k + 1);
        if (!rst_a[k]) model_reset(k);
        v = rst_a[k] && !m_busy[k] && (req0_a[k] || req1_a[k]);
        w = (req0_a[k] && req1_a[k]) ? !m_last[k] : req1_a[k];
        e_g0 = v && !w;
        e_g1 = v && w;
        e_en = rst_a[k] && m_busy[k] && m_t[k] == 1;
        e_we = e_en && m_we[k];
        e_a0 = rst_a[k] && m_busy[k] && m_t[k] == m_dur[k] && !m_owner[k];
        e_a1 = rst_a[k] && m_busy[k] && m_t[k] == m_dur[k] && m_owner[k];
        check({p, " gnt"}, {gnt1_a[k], gnt0_a[k]}, {e_g1, e_g0});
        check({p, " ack"}, {ack1_a[k], ack0_a[k]}, {e_a1, e_a0});
        check({p, " mem_en/we"}, {en_a[k], mwe_a[k]}, {e_en, e_we});
        check({p, " mem_addr"}, maddr_a[k], m_addr[k]);
        check({p, " mem_wdata"}, mwdata_a[k], m_wdata[k]);
        check({p, " rdata"}, rdata_a[k], m_rdata[k]);
        check({p, " cpu_stall"}, stall_a[k], req0_a[k] && !e_a0);
        eg0[k] = e_g0;
        if (v) begin
          m_busy[k]  = 1;
          m_t[k]     = 1;
          m_owner[k] = w;
          m_last[k]  = w;
          m_we[k]    = w ? we1_a[k] : we0_a[k];
          m_addr[k]  = w ? addr1_a[k] : addr0_a[k];
          m_wdata[k] = w ? wdata1_a[k] : wdata0_a[k];
          m_dur[k]   = m_we[k] ? 2 : 2 + k;
        end else if (rst_a[k] && m_busy[k]) begin
          if (m_t[k] == m_dur[k]) m_busy[k] = 0;
          else begin
            if (m_t[k] == m_dur[k] - 1 && !m_we[k]) m_rdata[k] = mrd_a[k];
            m_t[k]++;
          end
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
